wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter feeding the single write port of the 32×32 integer register file. It merges single-cycle ALU results with out-of-order-in-time load returns from the LSU, buffering loads in a small queue. It also tracks which destination registers have loads outstanding, so decode can stall on read-after-write and write-after-write hazards. Sits between EX/LSU and the register file, and exports hazard status to decode.

## Interface
- LQ_DEPTH, 2: load-return queue entries, power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alu_valid_i  in  1  ALU result present this cycle; always accepted.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  32  ALU result.
- ld_issue_i  in  1  load issued this cycle; marks rd busy.
- ld_issue_rd_i  in  5  destination of issued load.
- lsu_valid_i  in  1  load data valid.
- lsu_ready_o  out  1  queue can accept load data.
- lsu_rd_i  in  5  load destination.
- lsu_data_i  in  32  load data.
- rf_wr_en_o  out  1  regfile write enable (registered).
- rf_rd_addr_o  out  5  regfile write address (registered).
- rf_rd_data_o  out  32  regfile write data (registered).
- rs1_addr_i, rs2_addr_i, id_rd_addr_i  in  5 each  decode-stage register addresses.
- hazard_o  out  1  decode must stall.
- busy_o  out  32  outstanding-load scoreboard.

## Operation
- Queue: FIFO of {rd, data}, LQ_DEPTH entries.
  - Push when lsu_valid_i && lsu_ready_o.
  - lsu_ready_o = !full. It does not depend on a same-cycle pop.
- Arbitration, each cycle:
  - alu_valid_i with alu_rd_i≠0 → ALU wins and the queue holds.
  - Otherwise, if the queue is non-empty → pop the head.
  - The winner is registered into rf_* at the next edge.
  - A selection with rd=0 produces rf_wr_en_o=0.
- Starvation guard: if the queue has been full for 4 consecutive cycles, the next cycle pops the queue regardless of alu_valid_i.
  - That cycle's ALU result is dropped from arbitration and err_starve is flagged (internal; see Configuration).
  - Issue logic must never let this occur. Verification asserts it never fires in legal traffic.
- Scoreboard:
  - busy[rd] sets on ld_issue_i when rd≠0.
  - busy[rd] clears on the edge its queue entry is popped.
  - If set and clear hit the same rd in the same cycle, set wins.
  - busy[0] is always 0.
- hazard_o (combinational) = busy[rs1] | busy[rs2] | busy[id_rd].
- The queue is empty with no wrap on full/empty ambiguity: it uses an explicit count register, 0..LQ_DEPTH.
- Pointers wrap modulo LQ_DEPTH.

## Timing
- Reset values: rf_wr_en_o=0, rf_rd_addr_o=0, rf_rd_data_o=0, busy_o=0, count=0, lsu_ready_o=1, hazard_o=0, starvation counter=0.
- ALU → rf_wr_en_o: 1 cycle. The regfile commits at the following edge, so the value is visible 2 edges after the input.
- LSU → rf_wr_en_o: minimum 2 cycles (push, then pop/register).
- Simultaneous push and pop: permitted when not full; count is unchanged.
- Push while full: blocked by ready.
- Reset mid-operation: the queue is flushed and busy cleared; pending data is lost by design, because the pipeline is also flushed.

## Configuration
- WB_FORWARD_EN defined: adds outputs fwd1_hit_o, fwd2_hit_o (1 bit each) and fwd_data_o (32 bit).
  - A hit asserts when rf_wr_en_o is set and rf_rd_addr_o equals rs1/rs2 (≠0).
  - This covers the cycle in which the regfile read still returns the stale value.
  - With the macro defined, err_starve is also exported as err_starve_o.
- WB_FORWARD_EN undefined: none of these ports exist. Decode must wait one extra cycle after a write to the same register.

## Structure
- Shared package, in the core's common definitions header:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - The starvation limit constant, 4.
- One sub-module: wb_lq_fifo. Parameterised by depth and width, with count-based full/empty. The arbiter and scoreboard stay in wb_arbiter.

## Test plan
- ALU only: alu x5=0x1234 → next cycle rf_wr_en_o=1, addr 5, data 0x1234; alu_rd=0 → rf_wr_en_o stays 0.
- Load path: issue x7 → busy_o[7]=1, hazard_o=1 for rs1=7; LSU returns x7=0xDEAD with no ALU → written after 2 cycles, busy_o[7]=0 on the pop edge.
- Contention: ALU valid for 3 cycles while 2 loads arrive → ALU writes first in order, then both loads in FIFO order; lsu_ready_o=0 while count=2.
- Set/clear collision: pop of x9 in the same cycle as a new issue to x9 → busy_o[9] remains 1.
- Reset mid-stream: queue holds 2 entries, busy=0x180, rst pulsed → all outputs at reset values and no write occurs afterwards.
- With WB_FORWARD_EN: write x3=0x55 pending, rs2=3 → fwd2_hit_o=1, fwd_data_o=0x55; rs2=0 → no hit.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Common integer-core definitions shared by the writeback arbiter, its
// load-return queue and the bus interface.
//   REG_ADDR_W / XLEN / NUM_REGS : register-file geometry
//   STARVE_LIMIT                 : consecutive full-queue cycles before a
//                                  forced queue pop
//   lq_entry_t                   : one load-return queue entry {rd, data}
// No ports (package).
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;
    localparam int NUM_REGS     = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } lq_entry_t;

    localparam int LQ_ENTRY_W = $bits(lq_entry_t);

    // One-hot mask selecting a single register in a NUM_REGS-wide vector.
    function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the writeback arbiter's handshake/bus signals.
//   ALU result   : alu_valid_i, alu_rd_i, alu_data_i
//   Load issue   : ld_issue_i, ld_issue_rd_i
//   LSU return   : lsu_valid_i, lsu_ready_o, lsu_rd_i, lsu_data_i
//   Regfile port : rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o
//   Decode       : rs1_addr_i, rs2_addr_i, id_rd_addr_i, hazard_o, busy_o
// WB_FORWARD_EN adds fwd1_hit_o, fwd2_hit_o, fwd_data_o and err_starve_o.
// Modports: slave = arbiter side, master = surrounding pipeline side.
// -----------------------------------------------------------------------------
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                alu_valid_i;
    reg_addr_t           alu_rd_i;
    xlen_t               alu_data_i;
    logic                ld_issue_i;
    reg_addr_t           ld_issue_rd_i;
    logic                lsu_valid_i;
    logic                lsu_ready_o;
    reg_addr_t           lsu_rd_i;
    xlen_t               lsu_data_i;
    logic                rf_wr_en_o;
    reg_addr_t           rf_rd_addr_o;
    xlen_t               rf_rd_data_o;
    reg_addr_t           rs1_addr_i;
    reg_addr_t           rs2_addr_i;
    reg_addr_t           id_rd_addr_i;
    logic                hazard_o;
    logic [NUM_REGS-1:0] busy_o;
`ifdef WB_FORWARD_EN
    logic                fwd1_hit_o;
    logic                fwd2_hit_o;
    xlen_t               fwd_data_o;
    logic                err_starve_o;
`endif

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_issue_i, ld_issue_rd_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  rs1_addr_i, rs2_addr_i, id_rd_addr_i,
        output lsu_ready_o,
        output rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o,
        output hazard_o, busy_o
`ifdef WB_FORWARD_EN
        ,
        output fwd1_hit_o, fwd2_hit_o, fwd_data_o, err_starve_o
`endif
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_issue_i, ld_issue_rd_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output rs1_addr_i, rs2_addr_i, id_rd_addr_i,
        input  lsu_ready_o,
        input  rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o,
        input  hazard_o, busy_o
`ifdef WB_FORWARD_EN
        ,
        input  fwd1_hit_o, fwd2_hit_o, fwd_data_o, err_starve_o
`endif
    );

endinterface

// File: rtl/wb_lq_fifo.sv
// -----------------------------------------------------------------------------
// wb_lq_fifo
// Load-return queue: DEPTH x WIDTH FIFO with an explicit occupancy counter,
// so full and empty never alias. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
//   clk, rst     : clock, synchronous active-high reset (flushes the queue)
//   push_i       : write push_data_i (ignored while full)
//   pop_i        : advance the head (ignored while empty)
//   head_o       : entry at the head of the queue
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// -----------------------------------------------------------------------------
module wb_lq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writeback arbiter for the single write port of the integer register file.
// ALU results win every cycle they target a non-zero register; otherwise
// the head of the load-return queue is written. A starvation guard forces a
// queue pop after the queue has sat full for STARVE_LIMIT cycles. A busy
// scoreboard of outstanding loads drives the decode hazard signal.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : wb_arbiter_if.slave (ALU, load issue, LSU return, regfile
//                write port, decode addresses, hazard_o, busy_o)
//   LQ_DEPTH   : load-return queue entries (power of two, >= 2)
// Optional macro WB_FORWARD_EN: drives fwd1_hit_o/fwd2_hit_o/fwd_data_o
// (bypass of the registered write) and exports err_starve_o.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    lq_entry_t               lq_head;
    logic                    lq_full, lq_empty, lq_push, lq_pop;

    logic                    alu_req, starve, sel_alu, err_starve;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic                    rf_wr_en_q,   rf_wr_en_d;
    reg_addr_t               rf_rd_addr_q, rf_rd_addr_d;
    xlen_t                   rf_rd_data_q, rf_rd_data_d;
    logic [NUM_REGS-1:0]     busy_q,       busy_d;

    // Ready looks only at occupancy, never at a same-cycle pop.
    assign bus.lsu_ready_o = !lq_full;
    assign lq_push         = bus.lsu_valid_i && !lq_full;

    wb_lq_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH (LQ_ENTRY_W)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (lq_push),
        .push_data_i ({bus.lsu_rd_i, bus.lsu_data_i}),
        .pop_i       (lq_pop),
        .head_o      (lq_head),
        .full_o      (lq_full),
        .empty_o     (lq_empty)
    );

    always_comb begin
        alu_req      = bus.alu_valid_i && (bus.alu_rd_i != '0);
        // starve_cnt_q holds how many cycles in a row the queue was full.
        starve       = lq_full && (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
        lq_pop       = !lq_empty && (starve || !alu_req);
        sel_alu      = alu_req && !starve;
        err_starve   = starve && alu_req;

        rf_wr_en_d   = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_rd_data_d = rf_rd_data_q;
        if (lq_pop) begin
            if (lq_head.rd != '0) begin
                rf_wr_en_d   = 1'b1;
                rf_rd_addr_d = lq_head.rd;
                rf_rd_data_d = lq_head.data;
            end
        end else if (sel_alu) begin
            rf_wr_en_d   = 1'b1;
            rf_rd_addr_d = bus.alu_rd_i;
            rf_rd_data_d = bus.alu_data_i;
        end

        starve_cnt_d = '0;
        if (lq_full) begin
            starve_cnt_d = starve ? starve_cnt_q : starve_cnt_q + STARVE_CNT_W'(1);
        end

        // Clear first so a same-cycle issue to the popped rd keeps it busy.
        busy_d = busy_q;
        if (lq_pop) begin
            busy_d = busy_d & ~reg_mask(lq_head.rd);
        end
        if (bus.ld_issue_i && (bus.ld_issue_rd_i != '0)) begin
            busy_d = busy_d | reg_mask(bus.ld_issue_rd_i);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_q   <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
            busy_q       <= '0;
            starve_cnt_q <= '0;
        end else begin
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Issue logic is expected to keep the ALU from starving the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!err_starve);
        end
    end

    assign bus.rf_wr_en_o   = rf_wr_en_q;
    assign bus.rf_rd_addr_o = rf_rd_addr_q;
    assign bus.rf_rd_data_o = rf_rd_data_q;
    assign bus.busy_o       = busy_q;
    assign bus.hazard_o     = busy_q[bus.rs1_addr_i] | busy_q[bus.rs2_addr_i]
                            | busy_q[bus.id_rd_addr_i];

`ifdef WB_FORWARD_EN
    // Bypass the write that the regfile has not committed yet.
    assign bus.fwd1_hit_o   = rf_wr_en_q && (bus.rs1_addr_i != '0)
                            && (rf_rd_addr_q == bus.rs1_addr_i);
    assign bus.fwd2_hit_o   = rf_wr_en_q && (bus.rs2_addr_i != '0)
                            && (rf_rd_addr_q == bus.rs2_addr_i);
    assign bus.fwd_data_o   = rf_rd_data_q;
    assign bus.err_starve_o = err_starve;
`endif

endmodule
